grf_wb_sched: RTL and testbench
===============================

# grf_wb_sched

Write-port scheduler and scoreboard for the general register file. It shares the GRF's single write port between two sources: the in-order pipeline writeback, which has fixed priority, and results from the long-latency multiply/divide unit (MDU), which are buffered here. It also tracks registers with MDU writes still outstanding and raises a stall toward the hazard unit. It sits between the MEM/WB stage, the MDU, the decode-stage hazard logic and the GRF write port.

## Interface
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- STARVE_LIM, 4, cycles a buffered result may wait before `hold_req`
- MAX_OUT, 2, max MDU writes in flight (issued, not yet committed)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- wb_req  in  1  pipeline writeback request this cycle
- wb_addr  in  5  pipeline destination
- wb_data  in  32  pipeline write data
- wb_pc8  in  32  pipeline PC+8 of writing instruction
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  buffer can accept
- mdu_addr  in  5  MDU destination
- mdu_data  in  32  MDU result
- mdu_pc8  in  32  PC+8 of MDU instruction
- iss_valid  in  1  decode issues an MDU op this cycle
- iss_addr  in  5  its destination
- chk_rs, chk_rt, chk_rd  in  5 each  decode source/destination addresses to check
- stall  out  1  decode must stall
- hold_req  out  1  pipeline must present no writeback next cycle
- grf_we  out  1  GRF RegWr
- grf_a3  out  5  GRF A3
- grf_wd  out  32  GRF WD
- grf_pc8  out  32  GRF pc8

## Operation
- Effective pipeline request: `wb_req && wb_addr != 0`. A request to $0 counts as idle.
- Write-port mux (combinational):
  - Effective pipeline request → drive wb_* with `grf_we = 1`.
  - Else, if the FIFO is non-empty → drive the FIFO head with `grf_we = 1`, and dequeue at the clock edge (commit).
  - Else → `grf_we = 0`; `grf_a3`, `grf_wd`, `grf_pc8` = 0.
- FIFO:
  - Enqueue on `mdu_valid && mdu_ready`.
  - `mdu_ready = reset && !full`.
  - No bypass: an entry is eligible to commit from the cycle after enqueue.
  - MDU results with addr 0 are enqueued and committed with `grf_we = 0`, so they still clear the outstanding count.
  - Enqueue and dequeue in the same cycle while full is not possible, because ready is low.
- Scoreboard: `busy[31:0]`, bit 0 always 0.
  - Issue with `iss_addr != 0` sets `busy[iss_addr]`.
  - Commit clears `busy[head.addr]`.
  - If the same register is set and cleared in one cycle, the set wins.
- Outstanding counter `out_cnt`:
  - +1 on `iss_valid`, −1 on commit; both in one cycle → unchanged.
  - Never exceeds MAX_OUT, because `stall` covers it.
- stall (combinational) = `busy[chk_rs] | busy[chk_rt] | busy[chk_rd] | (out_cnt == MAX_OUT)`.
  - Decode must not assert `iss_valid` while stall is high; doing so is a protocol violation and the behaviour is undefined.
- Starvation counter `starve`:
  - Increments each cycle the head is valid but not committed.
  - Clears on commit, or when the FIFO is empty.
  - `hold_req` is a registered output, set when `starve` reaches STARVE_LIM−1 while still blocked, and cleared on the cycle the head commits.
  - The hazard unit turns `hold_req` into a WB bubble, which guarantees a commit within 1 cycle.

## Timing
- Reset (reset = 0, asynchronous):
  - FIFO empties; busy, out_cnt, starve and hold_req all go to 0.
  - Outputs: `stall = 0`, `grf_we = 0`, `mdu_ready = 0`.
  - Pending MDU results are discarded.
- Pipeline writeback latency to `grf_we`: 0 cycles (combinational pass-through).
- MDU result latency, from accept to `grf_we`: minimum 1 cycle; maximum STARVE_LIM+1 cycles for the head entry.
- `stall` deasserts in the cycle the matching commit is presented. The GRF forwards the write data to its read ports in that same cycle, so decode reads the correct value.

## Structure
- Shared package `grf_pkg`:
  - `REG_ZERO = 5'd0`
  - address width 5, data width 32
  - `wb_entry_t` {addr, data, pc8}
- Sub-module `wb_fifo` (parameterised depth, holds `wb_entry_t`, outputs full/empty/head). Everything else stays in the top module.

## Test plan
- Pipeline-only: wb_req, addr 5, data 0x1234 → same-cycle `grf_we = 1`, `grf_a3 = 5`, `grf_wd = 0x1234`. wb_addr = 0 → `grf_we = 0`.
- MDU commit: issue r8 → `stall` for `chk_rs = 8`. Result 0xDEAD to r8 accepted with the port idle → next cycle `grf_a3 = 8`; `stall` falls that cycle; `busy[8]` clear afterwards.
- Conflict: MDU result enqueued, wb_req held high every cycle → commit blocked; `hold_req = 1` after 4 blocked cycles. Bench drops wb_req → commit next cycle, `hold_req` clears.
- Back-pressure and limit: 2 issues → `stall = 1` from out_cnt. 2 results buffered under continuous wb_req → `mdu_ready = 0`. Third `mdu_valid` is held, not lost.
- Same-cycle set/clear: commit r3 while a new issue to r3 → `busy[3]` stays 1, out_cnt unchanged.
- Reset mid-operation: 1 buffered entry plus `busy[3]`, then assert reset → all outputs 0 immediately. After release, no commit occurs and `stall = 0`.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared types and constants for the GRF write-port scheduler.
package grf_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc8;
  } wb_entry_t;

  // One-hot register mask; $0 never participates in the scoreboard.
  function automatic logic [31:0] reg_mask(input logic [ADDR_W-1:0] a);
    reg_mask = (a == REG_ZERO) ? 32'd0 : (32'd1 << a);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO buffering MDU results until the GRF write port is free.
import grf_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_q, rd_q;
  wb_entry_t   mem_q [DEPTH];

  // Pointer registers; reset discards any buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/grf_wb_sched.sv
// GRF write-port arbiter: pipeline writeback has priority, buffered MDU results
// fill idle slots; a scoreboard of pending MDU destinations drives decode stall.
import grf_pkg::*;

module grf_wb_sched #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIM = 4,
  parameter int MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_req,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc8,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic [31:0] mdu_pc8,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  input  logic [4:0]  chk_rd,
  output logic        stall,
  output logic        hold_req,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc8
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int ST_W  = $clog2(STARVE_LIM + 1);

  logic             wb_eff, commit, enq, full, empty;
  wb_entry_t        head, mdu_entry;
  logic [31:0]      busy_q, busy_d, busy_vis, clr_mask, set_mask;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [ST_W-1:0]  starve_q, starve_d;
  logic             hold_q, hold_d;

  assign wb_eff    = wb_req && (wb_addr != REG_ZERO);
  assign commit    = !wb_eff && !empty;
  assign mdu_ready = reset && !full;
  assign enq       = mdu_valid && mdu_ready;
  assign mdu_entry = '{addr: mdu_addr, data: mdu_data, pc8: mdu_pc8};
  assign hold_req  = hold_q;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (enq),
    .push_data_i(mdu_entry),
    .pop_i      (commit),
    .full_o     (full),
    .empty_o    (empty),
    .head_o     (head)
  );

  // Write-port mux; $0 MDU results commit silently.
  always_comb begin
    grf_we  = 1'b0;
    grf_a3  = 5'd0;
    grf_wd  = 32'd0;
    grf_pc8 = 32'd0;
    if (wb_eff) begin
      grf_we  = 1'b1;
      grf_a3  = wb_addr;
      grf_wd  = wb_data;
      grf_pc8 = wb_pc8;
    end else if (commit && (head.addr != REG_ZERO)) begin
      grf_we  = 1'b1;
      grf_a3  = head.addr;
      grf_wd  = head.data;
      grf_pc8 = head.pc8;
    end else begin
      grf_we  = 1'b0;
    end
  end

  // Scoreboard, in-flight count and starvation tracking.
  always_comb begin
    clr_mask  = commit ? reg_mask(head.addr) : 32'd0;
    set_mask  = iss_valid ? reg_mask(iss_addr) : 32'd0;
    busy_vis  = busy_q & ~clr_mask;
    busy_d    = (busy_vis | set_mask) & ~32'd1;
    stall     = busy_vis[chk_rs] | busy_vis[chk_rt] | busy_vis[chk_rd] |
                (out_cnt_q == CNT_W'(MAX_OUT));
    out_cnt_d = out_cnt_q;
    case ({iss_valid, commit})
      2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
      2'b01:   out_cnt_d = (out_cnt_q != CNT_W'(0)) ? out_cnt_q - CNT_W'(1) : out_cnt_q;
      default: out_cnt_d = out_cnt_q;
    endcase
    if (commit || empty) begin
      starve_d = ST_W'(0);
    end else if (starve_q != ST_W'(STARVE_LIM)) begin
      starve_d = starve_q + ST_W'(1);
    end else begin
      starve_d = starve_q;
    end
    if (commit) begin
      hold_d = 1'b0;
    end else if (!empty && (starve_q == ST_W'(STARVE_LIM - 1))) begin
      hold_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 32'd0;
      out_cnt_q <= CNT_W'(0);
      starve_q  <= ST_W'(0);
      hold_q    <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      out_cnt_q <= out_cnt_d;
      starve_q  <= starve_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_grf_wb_sched.sv
// Directed + randomized bench for grf_wb_sched against a queue-based reference model.
import grf_pkg::*;

module tb_grf_wb_sched;

  localparam int DEPTH = 2;
  localparam int LIM   = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_req, mdu_valid, iss_valid;
  logic [4:0]  wb_addr, mdu_addr, iss_addr, chk_rs, chk_rt, chk_rd;
  logic [31:0] wb_data, wb_pc8, mdu_data, mdu_pc8;
  logic        mdu_ready, stall, hold_req, grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc8;

  always #5 clk = ~clk;

  grf_wb_sched #(.FIFO_DEPTH(DEPTH), .STARVE_LIM(LIM), .MAX_OUT(MAXO)) dut (
    .clk(clk), .reset(reset),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc8(wb_pc8),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr),
    .mdu_data(mdu_data), .mdu_pc8(mdu_pc8),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd),
    .stall(stall), .hold_req(hold_req),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc8(grf_pc8)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: buffered results, pending destinations, in-flight count,
  // how long the oldest result has been waiting, and the hold flag.
  wb_entry_t   mq[$];
  bit          mbusy[32];
  int          mout, mwait;
  bit          mhold, m_acc;
  logic        e_we, e_stall, e_ready, e_commit;
  logic [4:0]  e_a3;
  logic [31:0] e_wd, e_pc8;
  int          pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    pend.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mout  = 0;
    mwait = 0;
    mhold = 1'b0;
  endfunction

  function automatic bit pending_reg(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (e_commit && mq[0].addr == r) return 1'b0;
    return mbusy[r];
  endfunction

  function automatic void model_comb();
    bit wbe;
    wbe      = wb_req && (wb_addr != 5'd0);
    e_commit = !wbe && (mq.size() > 0);
    e_ready  = (mq.size() < DEPTH);
    e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0; e_pc8 = 32'd0;
    if (wbe) begin
      e_we = 1'b1; e_a3 = wb_addr; e_wd = wb_data; e_pc8 = wb_pc8;
    end else if (e_commit && mq[0].addr != 5'd0) begin
      e_we = 1'b1; e_a3 = mq[0].addr; e_wd = mq[0].data; e_pc8 = mq[0].pc8;
    end
    e_stall = pending_reg(chk_rs) || pending_reg(chk_rt) || pending_reg(chk_rd) || (mout == MAXO);
  endfunction

  function automatic void model_update();
    wb_entry_t h;
    m_acc = mdu_valid && e_ready;
    if (e_commit) begin
      h = mq.pop_front();
      mbusy[h.addr] = 1'b0;
      if (mout > 0) mout--;
      mwait = 0;
      mhold = 1'b0;
    end else if (mq.size() > 0) begin
      mwait++;
      if (mwait >= LIM) mhold = 1'b1;
    end else begin
      mwait = 0;
    end
    if (iss_valid) begin
      mout++;
      if (iss_addr != 5'd0) mbusy[iss_addr] = 1'b1;
    end
    if (m_acc) mq.push_back('{addr: mdu_addr, data: mdu_data, pc8: mdu_pc8});
  endfunction

  task automatic tick();
    @(negedge clk);
    model_comb();
    chk("grf_we", grf_we, e_we);
    chk("grf_a3", grf_a3, e_a3);
    chk("grf_wd", grf_wd, e_wd);
    chk("grf_pc8", grf_pc8, e_pc8);
    chk("stall", stall, e_stall);
    chk("mdu_ready", mdu_ready, e_ready);
    chk("hold_req", hold_req, mhold);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_req = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_pc8 = 32'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0; mdu_pc8 = 32'd0;
    iss_valid = 1'b0; iss_addr = 5'd0;
    chk_rs = 5'd0; chk_rt = 5'd0; chk_rd = 5'd0;
  endtask

  task automatic mdu_put(input logic [4:0] a, input logic [31:0] d);
    mdu_valid = 1'b1; mdu_addr = a; mdu_data = d; mdu_pc8 = {24'd0, 3'd0, a} + 32'h400;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit hold_mdu;
    int tries;
    reset = 1'b0;
    idle();
    model_reset();
    #2;
    chk("rst_stall", stall, 1'b0);
    chk("rst_we", grf_we, 1'b0);
    chk("rst_ready", mdu_ready, 1'b0);
    chk("rst_hold", hold_req, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Pipeline-only writeback passes through combinationally.
    wb_req = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; wb_pc8 = 32'h3008;
    #2;
    chk("pipe_we", grf_we, 1'b1);
    chk("pipe_a3", grf_a3, 5'd5);
    chk("pipe_wd", grf_wd, 32'h1234);
    tick();
    wb_addr = 5'd0;
    #2;
    chk("pipe_zero_we", grf_we, 1'b0);
    tick();
    idle();

    // MDU issue to r8, result commits on an idle port the next cycle.
    iss_valid = 1'b1; iss_addr = 5'd8;
    tick();
    iss_valid = 1'b0; chk_rs = 5'd8;
    #2;
    chk("busy8_stall", stall, 1'b1);
    tick();
    mdu_put(5'd8, 32'hDEAD);
    tick();
    mdu_valid = 1'b0;
    #2;
    chk("commit8_a3", grf_a3, 5'd8);
    chk("commit8_wd", grf_wd, 32'hDEAD);
    chk("commit8_stall", stall, 1'b0);
    tick();
    #2;
    chk("after8_stall", stall, 1'b0);
    tick();
    idle();

    // Continuous writeback starves a buffered result until hold_req.
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    iss_valid = 1'b0;
    wb_req = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
    mdu_put(5'd9, 32'h9999);
    tick();
    mdu_valid = 1'b0;
    repeat (3) tick();
    #2;
    chk("hold_early", hold_req, 1'b0);
    tick();
    #2;
    chk("hold_set", hold_req, 1'b1);
    wb_req = 1'b0;
    #1;
    chk("starve_commit_a3", grf_a3, 5'd9);
    chk("starve_commit_we", grf_we, 1'b1);
    tick();
    #2;
    chk("hold_clear", hold_req, 1'b0);
    tick();
    idle();

    // Back-pressure and in-flight limit.
    iss_valid = 1'b1; iss_addr = 5'd10;
    tick();
    iss_addr = 5'd11;
    tick();
    iss_valid = 1'b0;
    #2;
    chk("limit_stall", stall, 1'b1);
    wb_req = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    mdu_put(5'd10, 32'hA0A0);
    tick();
    mdu_put(5'd11, 32'hB1B1);
    tick();
    mdu_put(5'd0, 32'h333);
    #2;
    chk("full_ready", mdu_ready, 1'b0);
    repeat (2) tick();
    wb_req = 1'b0;
    tries = 0;
    m_acc = 1'b0;
    while (!m_acc && tries < 10) begin
      tick();
      tries++;
    end
    chk("third_accepted", m_acc, 1'b1);
    mdu_valid = 1'b0;
    repeat (4) tick();
    idle();

    // Same-cycle set/clear of r3: set wins, count unchanged.
    iss_valid = 1'b1; iss_addr = 5'd3;
    tick();
    iss_valid = 1'b0;
    mdu_put(5'd3, 32'h3333);
    tick();
    mdu_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd3;
    tick();
    iss_valid = 1'b0; chk_rs = 5'd3;
    #2;
    chk("setwins_busy3", stall, 1'b1);
    tick();
    chk_rs = 5'd0;
    iss_valid = 1'b1; iss_addr = 5'd12;
    tick();
    iss_valid = 1'b0;
    #2;
    chk("setwins_cnt", stall, 1'b1);
    mdu_put(5'd3, 32'h3131);
    tick();
    mdu_put(5'd12, 32'h1212);
    tick();
    idle();
    repeat (3) tick();

    // Randomized traffic obeying the decode/hazard/MDU protocols.
    hold_mdu = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic [4:0] cand;
      wb_req  = mhold ? 1'b0 : ($urandom_range(0, 99) < 55);
      wb_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data = $urandom();
      wb_pc8  = $urandom();
      if (!hold_mdu) begin
        if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
          mdu_valid = 1'b1; mdu_addr = 5'(pend[0]);
          mdu_data = $urandom(); mdu_pc8 = $urandom();
        end else begin
          mdu_valid = 1'b0;
        end
      end
      cand   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      chk_rs = 5'($urandom_range(0, 31));
      chk_rt = 5'($urandom_range(0, 31));
      chk_rd = cand;
      model_comb();
      iss_valid = !e_stall && ($urandom_range(0, 99) < 40);
      iss_addr  = cand;
      if (iss_valid) pend.push_back(int'(cand));
      tick();
      if (m_acc) void'(pend.pop_front());
      hold_mdu = mdu_valid && !m_acc;
    end
    idle();
    repeat (8) tick();

    // Reset mid-operation with a buffered entry and busy[3].
    iss_valid = 1'b1; iss_addr = 5'd3;
    tick();
    iss_addr = 5'd5;
    tick();
    iss_valid = 1'b0;
    wb_req = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    mdu_put(5'd3, 32'h3030);
    tick();
    idle();
    chk_rs = 5'd3;
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_we", grf_we, 1'b0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_ready", mdu_ready, 1'b0);
    chk("midrst_hold", hold_req, 1'b0);
    chk("midrst_a3", grf_a3, 5'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) tick();
    #2;
    chk("postrst_we", grf_we, 1'b0);
    chk("postrst_stall", stall, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
